// File: rtl/mandel_pkg.sv
// ----------------------------------------------------------------------------
// mandel_pkg
// Shared definitions for the Mandelbrot iteration engine: datapath width,
// fixed-point format, the |z|^2 escape limit and the engine state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package mandel_pkg;

    // Coordinates are signed Q4.28 words
    localparam int WIDTH     = 32;
    localparam int FRAC_BITS = 28;

    // 4.0 expressed in the Q9.56 format of the summed squares (4 << 56)
    localparam logic signed [64:0] ESCAPE_R2 = 65'sh0400_0000_0000_0000;

    typedef logic signed [WIDTH-1:0] fixed_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        UPD,
        DONE
    } state_t;

endpackage

// File: rtl/mandel_iter_engine_fx_mul.sv
// ----------------------------------------------------------------------------
// fx_mul
// Signed 32x32 -> 64 multiplier with a registered product. The product only
// updates while en is high so it stays valid for the cycle after.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset (clears the product)
//   en    - load a new product on this edge
//   a, b  - signed operands
//   p     - registered full-precision signed product
// ----------------------------------------------------------------------------
module fx_mul
    import mandel_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  fixed_t             a,
    input  fixed_t             b,
    output logic signed [63:0] p
);

    // Both operands are sign-extended to 64 bits first so the full product
    // is kept without any overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
        end else if (en) begin
            p <= 64'(a) * 64'(b);
        end
    end

endmodule

// File: rtl/mandel_iter_engine.sv
// ----------------------------------------------------------------------------
// mandel_iter_engine
// Iterates z <- z^2 + c for one pixel at a time in Q4.28 fixed point and
// reports the escape count. Each iteration takes two cycles: MUL registers
// the three products, UPD tests for termination or updates z.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   in_valid       - a pixel job is offered
//   in_ready       - engine is idle and can take a job
//   c_re, c_im     - signed Q4.28 point c
//   max_iter       - iteration limit
//   in_tag         - pixel identifier carried to out_tag
//   out_valid      - result available (held until out_ready)
//   out_ready      - downstream accepts the result
//   iterations     - escape count (or max_iter if the point never escaped)
//   out_tag        - tag of the job that produced iterations
// ----------------------------------------------------------------------------
module mandel_iter_engine
    import mandel_pkg::*;
#(
    parameter int FRAC_BITS = mandel_pkg::FRAC_BITS,
    parameter int TAG_W     = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      c_re,
    input  logic [31:0]      c_im,
    input  logic [31:0]      max_iter,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      iterations,
    output logic [TAG_W-1:0] out_tag
);

    state_t             state;
    fixed_t             zr;
    fixed_t             zi;
    logic [31:0]        n;
    fixed_t             c_re_q;
    fixed_t             c_im_q;
    logic [31:0]        max_iter_q;
    logic [TAG_W-1:0]   tag_q;

    logic signed [63:0] p_rr;
    logic signed [63:0] p_ii;
    logic signed [63:0] p_ri;
    logic               mul_en;

    logic signed [64:0] mag;
    logic signed [63:0] diff;
    logic signed [63:0] twice_ri;
    logic               escape;
    logic               terminate;
    fixed_t             zr_next;
    fixed_t             zi_next;

    assign mul_en = (state == MUL);

    fx_mul u_mul_rr (.clk(clk), .rst_n(rst_n), .en(mul_en), .a(zr), .b(zr), .p(p_rr));
    fx_mul u_mul_ii (.clk(clk), .rst_n(rst_n), .en(mul_en), .a(zi), .b(zi), .p(p_ii));
    fx_mul u_mul_ri (.clk(clk), .rst_n(rst_n), .en(mul_en), .a(zr), .b(zi), .p(p_ri));

    // UPD datapath. The squares are summed one bit wider so the Q9.56
    // magnitude cannot overflow; exactly 4.0 is not an escape. The new z is
    // taken from the products with an arithmetic shift, which truncates
    // toward minus infinity, then wraps to 32 bits when c is added.
    always_comb begin
        mag       = {p_rr[63], p_rr} + {p_ii[63], p_ii};
        escape    = (mag > ESCAPE_R2);
        terminate = (n == max_iter_q) || escape;
        diff      = p_rr - p_ii;
        twice_ri  = p_ri <<< 1;
        zr_next   = fixed_t'(diff >>> FRAC_BITS) + c_re_q;
        zi_next   = fixed_t'(twice_ri >>> FRAC_BITS) + c_im_q;
    end

    // Control FSM with registered handshake outputs. in_ready is only ever
    // high in IDLE; it comes up one edge after reset or together with the
    // DONE -> IDLE edge, and drops on the accepting edge. The n == max_iter
    // check in terminate guarantees n never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            iterations <= '0;
            out_tag    <= '0;
            zr         <= '0;
            zi         <= '0;
            n          <= '0;
            c_re_q     <= '0;
            c_im_q     <= '0;
            max_iter_q <= '0;
            tag_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_ready && in_valid) begin
                        c_re_q     <= c_re;
                        c_im_q     <= c_im;
                        max_iter_q <= max_iter;
                        tag_q      <= in_tag;
                        zr         <= '0;
                        zi         <= '0;
                        n          <= '0;
                        in_ready   <= 1'b0;
                        state      <= MUL;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                MUL: begin
                    state <= UPD;
                end
                UPD: begin
                    if (terminate) begin
                        iterations <= n;
                        out_tag    <= tag_q;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        zr    <= zr_next;
                        zi    <= zi_next;
                        n     <= n + 32'd1;
                        state <= MUL;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
